// File: rtl/z80_ram_bridge_if.sv
// z80_ram_bridge_if
//   Groups the RC2014 backplane signals and the synchronous byte-RAM port
//   that z80_ram_bridge sits between.
//   Z80 side : mreq_n, rd_n, wr_n, z_addr, z_din (to bridge);
//              z_dout, z_doe, wait_n (from bridge).
//   RAM side : ram_ce, ram_wen, ram_addr, ram_wdata (from bridge);
//              ram_rdata (to bridge, valid the cycle after ram_ce).
//   master : the bridge itself.  slave : the backplane/RAM environment.
interface z80_ram_bridge_if;
    logic        mreq_n;
    logic        rd_n;
    logic        wr_n;
    logic [15:0] z_addr;
    logic [7:0]  z_din;
    logic [7:0]  z_dout;
    logic        z_doe;
    logic        wait_n;
    logic        ram_ce;
    logic        ram_wen;
    logic [16:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    modport master (
        input  mreq_n, rd_n, wr_n, z_addr, z_din, ram_rdata,
        output z_dout, z_doe, wait_n, ram_ce, ram_wen, ram_addr, ram_wdata
    );

    modport slave (
        output mreq_n, rd_n, wr_n, z_addr, z_din, ram_rdata,
        input  z_dout, z_doe, wait_n, ram_ce, ram_wen, ram_addr, ram_wdata
    );
endinterface

// File: rtl/z80_ram_bridge.sv
// z80_ram_bridge
//   Turns asynchronous Z80 memory cycles into single-clock ce/wen accesses
//   on a synchronous byte RAM with one-cycle registered read latency.
//   Strobes are double-flop synchronised; the cycle is stretched with WAIT
//   until the RAM access is done, and read data is driven back while MREQ
//   stays low.
//   Ports:
//     clk     : system clock
//     reset_n : asynchronous active-low reset
//     bus     : z80_ram_bridge_if.master (Z80 pins and RAM port)
module z80_ram_bridge #(
    parameter logic [15:0] RAM_BASE = 16'h8000,
    parameter int unsigned RAM_LAST = 16000
) (
    input logic               clk,
    input logic               reset_n,
    z80_ram_bridge_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_CAP,
        WR_REQ,
        HOLD
    } state_t;

    state_t      state;
    logic [1:0]  mreq_sync;
    logic [1:0]  rd_sync;
    logic [1:0]  wr_sync;
    logic        mreq_s;
    logic        rd_s;
    logic        wr_s;
    logic [16:0] offset;
    logic        hit;

    assign mreq_s = mreq_sync[1];
    assign rd_s   = rd_sync[1];
    assign wr_s   = wr_sync[1];

    // 17-bit compare so addresses near 16'hFFFF cannot wrap into the window.
    always_comb begin
        offset = {1'b0, bus.z_addr} - {1'b0, RAM_BASE};
        hit    = ({1'b0, bus.z_addr} >= {1'b0, RAM_BASE}) &&
                 (offset <= 17'(RAM_LAST));
    end

    // Outputs are registered on the transition into the state that owns
    // them, so ram_ce/ram_wen/wait_n line up exactly with RD_REQ/WR_REQ.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            mreq_sync     <= '1;
            rd_sync       <= '1;
            wr_sync       <= '1;
            bus.z_dout    <= '0;
            bus.z_doe     <= 1'b0;
            bus.wait_n    <= 1'b1;
            bus.ram_ce    <= 1'b0;
            bus.ram_wen   <= 1'b0;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
        end else begin
            mreq_sync   <= {mreq_sync[0], bus.mreq_n};
            rd_sync     <= {rd_sync[0], bus.rd_n};
            wr_sync     <= {wr_sync[0], bus.wr_n};
            bus.ram_ce  <= 1'b0;
            bus.ram_wen <= 1'b0;
            bus.wait_n  <= 1'b1;

            case (state)
                IDLE: begin
                    // rd_s != wr_s rejects refresh (both high) and the
                    // illegal both-low case in one term.
                    if (!mreq_s && hit && (rd_s != wr_s)) begin
                        bus.ram_addr <= offset;
                        bus.ram_ce   <= 1'b1;
                        bus.wait_n   <= 1'b0;
                        if (!rd_s) begin
                            state <= RD_REQ;
                        end else begin
                            state         <= WR_REQ;
                            bus.ram_wen   <= 1'b1;
                            bus.ram_wdata <= bus.z_din;
                        end
                    end
                end
                RD_REQ: begin
                    state      <= RD_CAP;
                    bus.wait_n <= 1'b0;
                end
                RD_CAP: begin
                    state      <= HOLD;
                    bus.z_dout <= bus.ram_rdata;
                    // An aborted read still captures but never drives the bus.
                    bus.z_doe  <= ~mreq_s;
                end
                WR_REQ: begin
                    state <= HOLD;
                end
                HOLD: begin
                    if (mreq_s) begin
                        state     <= IDLE;
                        bus.z_doe <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_z80_ram_bridge.sv
// tb_z80_ram_bridge
//   Self-checking bench for z80_ram_bridge: directed scenarios plus a
//   randomized sequence checked against an address-keyed memory model.
module tb_z80_ram_bridge;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    z80_ram_bridge_if bus ();

    z80_ram_bridge #(
        .RAM_BASE (16'h8000),
        .RAM_LAST (16000)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    int checks   = 0;
    int failures = 0;

    // Synchronous byte RAM environment with one-cycle registered read.
    logic [7:0] ram_mem [0:131071];
    always @(posedge clk) begin
        if (bus.ram_ce === 1'b1) begin
            if (bus.ram_wen === 1'b1) ram_mem[bus.ram_addr] <= bus.ram_wdata;
            else                      bus.ram_rdata <= ram_mem[bus.ram_addr];
        end
    end

    // Bus monitor: sole writer of the activity counters.
    int          cyc = 0;
    int          ce_cnt = 0, wen_cnt = 0, wait_cnt = 0, doe_rise = 0;
    int          ce_cyc = 0, doe_rise_cyc = 0;
    logic [16:0] ce_addr = '0;
    logic [7:0]  ce_wdata = '0, doe_data = '0;
    bit          doe_prev = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (bus.ram_ce === 1'b1) begin
            ce_cnt++;
            ce_cyc   = cyc;
            ce_addr  = bus.ram_addr;
            ce_wdata = bus.ram_wdata;
            if (bus.ram_wen === 1'b1) wen_cnt++;
        end
        if (bus.wait_n === 1'b0) wait_cnt++;
        if (bus.z_doe === 1'b1 && !doe_prev) begin
            doe_rise++;
            doe_rise_cyc = cyc;
            doe_data     = bus.z_dout;
        end
        doe_prev = (bus.z_doe === 1'b1);
    end

    int b_ce, b_wen, b_wait, b_doe;
    task automatic mark();
        b_ce   = ce_cnt;
        b_wen  = wen_cnt;
        b_wait = wait_cnt;
        b_doe  = doe_rise;
    endtask

    // Reference memory keyed by Z80 address.
    logic [7:0] mem_ref [int];

    function automatic bit ref_hit(input int a);
        return (a >= 32768) && (a - 32768 <= 16000);
    endfunction

    task automatic bus_cycle(input bit wr, input logic [15:0] a, input logic [7:0] d);
        @(posedge clk); #2;
        bus.z_addr = a;
        bus.z_din  = d;
        bus.mreq_n = 1'b0;
        if (wr) bus.wr_n = 1'b0;
        else    bus.rd_n = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        bus.mreq_n = 1'b1;
        bus.rd_n   = 1'b1;
        bus.wr_n   = 1'b1;
        repeat (6) @(posedge clk);
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        bus.mreq_n = 1'b1;
        bus.rd_n   = 1'b1;
        bus.wr_n   = 1'b1;
        bus.z_addr = '0;
        bus.z_din  = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.wait_n !== 1'b1) begin failures++; $display("FAIL reset_wait_n: got %b expected 1", bus.wait_n); end
        checks++; if (bus.z_doe !== 1'b0) begin failures++; $display("FAIL reset_z_doe: got %b expected 0", bus.z_doe); end
        checks++; if (bus.ram_ce !== 1'b0) begin failures++; $display("FAIL reset_ram_ce: got %b expected 0", bus.ram_ce); end
        checks++; if (bus.ram_addr !== 17'd0) begin failures++; $display("FAIL reset_ram_addr: got %0h expected 0", bus.ram_addr); end
        checks++; if (bus.z_dout !== 8'd0) begin failures++; $display("FAIL reset_z_dout: got %0h expected 0", bus.z_dout); end
        #2 reset_n = 1'b1;
        mark();
        repeat (10) @(posedge clk);
        checks++; if (ce_cnt - b_ce !== 0) begin failures++; $display("FAIL idle_no_ce: got %0d accesses expected 0", ce_cnt - b_ce); end
    endtask

    task automatic test_write();
        mark();
        bus_cycle(1'b1, 16'h8005, 8'hA5);
        mem_ref[32'h8005] = 8'hA5;
        checks++; if (ce_cnt - b_ce !== 1) begin failures++; $display("FAIL write_ce_count: got %0d expected 1", ce_cnt - b_ce); end
        checks++; if (wen_cnt - b_wen !== 1) begin failures++; $display("FAIL write_wen_count: got %0d expected 1", wen_cnt - b_wen); end
        checks++; if (ce_addr !== 17'd5) begin failures++; $display("FAIL write_addr: got %0h expected 5", ce_addr); end
        checks++; if (ce_wdata !== 8'hA5) begin failures++; $display("FAIL write_data: got %0h expected a5", ce_wdata); end
        checks++; if (wait_cnt - b_wait !== 1) begin failures++; $display("FAIL write_wait_cycles: got %0d expected 1", wait_cnt - b_wait); end
        checks++; if (doe_rise - b_doe !== 0) begin failures++; $display("FAIL write_no_doe: got %0d expected 0", doe_rise - b_doe); end
    endtask

    task automatic test_read();
        mark();
        bus_cycle(1'b0, 16'h8005, 8'h00);
        checks++; if (ce_cnt - b_ce !== 1) begin failures++; $display("FAIL read_ce_count: got %0d expected 1", ce_cnt - b_ce); end
        checks++; if (wen_cnt - b_wen !== 0) begin failures++; $display("FAIL read_wen_count: got %0d expected 0", wen_cnt - b_wen); end
        checks++; if (wait_cnt - b_wait !== 2) begin failures++; $display("FAIL read_wait_cycles: got %0d expected 2", wait_cnt - b_wait); end
        checks++; if (doe_rise - b_doe !== 1) begin failures++; $display("FAIL read_doe_rise: got %0d expected 1", doe_rise - b_doe); end
        checks++; if (doe_rise_cyc - ce_cyc !== 2) begin failures++; $display("FAIL read_latency: got %0d expected 2", doe_rise_cyc - ce_cyc); end
        checks++; if (doe_data !== 8'hA5) begin failures++; $display("FAIL read_data: got %0h expected a5", doe_data); end
        checks++; if (bus.z_doe !== 1'b0) begin failures++; $display("FAIL read_doe_release: got %b expected 0", bus.z_doe); end
        checks++; if (bus.z_dout !== 8'hA5) begin failures++; $display("FAIL read_dout_hold: got %0h expected a5", bus.z_dout); end
    endtask

    task automatic test_decode_bounds();
        mark();
        bus_cycle(1'b1, 16'h7FFF, 8'h11);
        checks++; if (ce_cnt - b_ce !== 0) begin failures++; $display("FAIL decode_below: got %0d expected 0", ce_cnt - b_ce); end
        mark();
        bus_cycle(1'b1, 16'h8000 + 16'd16000, 8'h5A);
        mem_ref[32768 + 16000] = 8'h5A;
        checks++; if (ce_cnt - b_ce !== 1) begin failures++; $display("FAIL decode_last: got %0d expected 1", ce_cnt - b_ce); end
        checks++; if (ce_addr !== 17'd16000) begin failures++; $display("FAIL decode_last_addr: got %0d expected 16000", ce_addr); end
        mark();
        bus_cycle(1'b1, 16'h8000 + 16'd16001, 8'h22);
        checks++; if (ce_cnt - b_ce !== 0) begin failures++; $display("FAIL decode_above: got %0d expected 0", ce_cnt - b_ce); end
        mark();
        bus_cycle(1'b0, 16'hFFFF, 8'h00);
        checks++; if (ce_cnt - b_ce !== 0) begin failures++; $display("FAIL decode_ffff: got %0d expected 0", ce_cnt - b_ce); end
        mark();
        bus_cycle(1'b0, 16'h8000 + 16'd16000, 8'h00);
        checks++; if (doe_data !== 8'h5A) begin failures++; $display("FAIL decode_last_read: got %0h expected 5a", doe_data); end
    endtask

    task automatic test_refresh_illegal();
        mark();
        @(posedge clk); #2;
        bus.z_addr = 16'h8010;
        bus.z_din  = 8'h3C;
        bus.mreq_n = 1'b0;
        repeat (20) @(posedge clk);
        checks++; if (ce_cnt - b_ce !== 0) begin failures++; $display("FAIL refresh_no_ce: got %0d expected 0", ce_cnt - b_ce); end
        #2 bus.wr_n = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        bus.mreq_n = 1'b1;
        bus.wr_n   = 1'b1;
        repeat (6) @(posedge clk);
        mem_ref[32'h8010] = 8'h3C;
        checks++; if (wen_cnt - b_wen !== 1) begin failures++; $display("FAIL late_wr_write: got %0d expected 1", wen_cnt - b_wen); end
        checks++; if (ce_addr !== 17'h10 || ce_wdata !== 8'h3C) begin failures++; $display("FAIL late_wr_addr_data: got %0h/%0h expected 10/3c", ce_addr, ce_wdata); end
        mark();
        @(posedge clk); #2;
        bus.z_addr = 16'h8020;
        bus.mreq_n = 1'b0;
        bus.rd_n   = 1'b0;
        bus.wr_n   = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        bus.mreq_n = 1'b1;
        bus.rd_n   = 1'b1;
        bus.wr_n   = 1'b1;
        repeat (6) @(posedge clk);
        checks++; if (ce_cnt - b_ce !== 0) begin failures++; $display("FAIL illegal_no_ce: got %0d expected 0", ce_cnt - b_ce); end
    endtask

    task automatic test_abort();
        bus_cycle(1'b1, 16'h8030, 8'h77);
        mem_ref[32'h8030] = 8'h77;
        mark();
        @(posedge clk); #2;
        bus.z_addr = 16'h8030;
        bus.mreq_n = 1'b0;
        bus.rd_n   = 1'b0;
        @(posedge clk); #2;
        bus.mreq_n = 1'b1;
        repeat (8) @(posedge clk);
        #2 bus.rd_n = 1'b1;
        repeat (4) @(posedge clk);
        checks++; if (ce_cnt - b_ce !== 1) begin failures++; $display("FAIL abort_ce_count: got %0d expected 1", ce_cnt - b_ce); end
        checks++; if (wen_cnt - b_wen !== 0) begin failures++; $display("FAIL abort_wen: got %0d expected 0", wen_cnt - b_wen); end
        checks++; if (doe_rise - b_doe !== 0) begin failures++; $display("FAIL abort_no_doe: got %0d expected 0", doe_rise - b_doe); end
        checks++; if (bus.z_dout !== 8'h77) begin failures++; $display("FAIL abort_capture: got %0h expected 77", bus.z_dout); end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        @(posedge clk); #2;
        bus.z_addr = 16'h8005;
        bus.mreq_n = 1'b0;
        bus.rd_n   = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.ram_ce === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL reset_mid_timeout: got no ram_ce within 20 clk expected one");
        end else begin
            @(posedge clk); #2;
            reset_n = 1'b0;
            #1;
            checks++; if (bus.wait_n !== 1'b1 || bus.z_doe !== 1'b0) begin failures++; $display("FAIL reset_mid_wait_doe: got %b/%b expected 1/0", bus.wait_n, bus.z_doe); end
            checks++; if (bus.ram_ce !== 1'b0 || bus.ram_wen !== 1'b0) begin failures++; $display("FAIL reset_mid_ce_wen: got %b/%b expected 0/0", bus.ram_ce, bus.ram_wen); end
            checks++; if (bus.ram_addr !== 17'd0 || bus.ram_wdata !== 8'd0 || bus.z_dout !== 8'd0) begin failures++; $display("FAIL reset_mid_data: got %0h/%0h/%0h expected 0/0/0", bus.ram_addr, bus.ram_wdata, bus.z_dout); end
        end
        bus.mreq_n = 1'b1;
        bus.rd_n   = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int         ai;
            bit         wr;
            logic [7:0] d;
            case ($urandom_range(0, 3))
                0:       ai = 32768 + int'($urandom_range(0, 15));
                1:       ai = 32768 + int'($urandom_range(0, 16000));
                2:       ai = 32768 + int'($urandom_range(15990, 16010));
                default: ai = int'($urandom_range(0, 65535));
            endcase
            d  = 8'($urandom);
            wr = ($urandom_range(0, 1) == 1) || !mem_ref.exists(ai);
            mark();
            bus_cycle(wr, 16'(ai), d);
            if (!ref_hit(ai)) begin
                checks++; if (ce_cnt - b_ce !== 0) begin failures++; $display("FAIL rand_miss a=%0h: got %0d accesses expected 0", ai, ce_cnt - b_ce); end
            end else if (wr) begin
                mem_ref[ai] = d;
                checks++; if (wen_cnt - b_wen !== 1 || ce_cnt - b_ce !== 1) begin failures++; $display("FAIL rand_write_count a=%0h: got %0d/%0d expected 1/1", ai, ce_cnt - b_ce, wen_cnt - b_wen); end
                checks++; if (ce_addr !== 17'(ai - 32768) || ce_wdata !== d) begin failures++; $display("FAIL rand_write a=%0h: got %0h/%0h expected %0h/%0h", ai, ce_addr, ce_wdata, ai - 32768, d); end
            end else begin
                checks++; if (ce_cnt - b_ce !== 1 || wen_cnt - b_wen !== 0) begin failures++; $display("FAIL rand_read_count a=%0h: got %0d/%0d expected 1/0", ai, ce_cnt - b_ce, wen_cnt - b_wen); end
                checks++; if (doe_rise - b_doe !== 1 || doe_data !== mem_ref[ai]) begin failures++; $display("FAIL rand_read a=%0h: got %0d/%0h expected 1/%0h", ai, doe_rise - b_doe, doe_data, mem_ref[ai]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_decode_bounds();
        test_refresh_illegal();
        test_abort();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got no completion within 2 ms expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
